// File: rtl/life_step_ctrl.sv
// rtl/life_step_ctrl.sv - Game of Life generation sequencer over a row-addressed grid store
module life_step_ctrl #(
  parameter int ROWS  = 24,
  parameter int COLS  = 32,
  parameter int TORUS = 1
) (
  input  logic        out_stream_aclk,
  input  logic        periph_resetn,
  input  logic        step_en,
  input  logic        step_req,
  input  logic        frame_start,
  input  logic [3:0]  frame_div,
  output logic        rd_en,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] gen_count
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRIME_A,
    PRIME_B,
    PRIME_C,
    ROW_RD,
    ROW_CAP,
    ROW_WR,
    FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic        pend_q, pend_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic [4:0]  frame_inc;
  logic [4:0]  div_eff;
  logic        frame_trig;

  // Sliding three-row window plus the untouched copy of row 0 for the final wrap.
  logic [31:0] prev_q, cur_q, nxt_q, row0_q;
  logic [31:0] nxt_in;

  logic        rd_go;
  logic [4:0]  rd_addr_d;
  logic        wr_go;

  // One cell-generation step for a whole row; count is 4 bits so 8 neighbours fit.
  function automatic logic [31:0] life_row(input logic [31:0] p,
                                           input logic [31:0] c,
                                           input logic [31:0] n);
    logic [31:0] res;
    logic [3:0]  cnt;
    logic [4:0]  lc;
    logic [4:0]  rc;
    res = '0;
    for (int k = 0; k < COLS; k++) begin
      lc  = (k == 0) ? 5'(COLS - 1) : 5'(k - 1);
      rc  = (k == COLS - 1) ? 5'd0 : 5'(k + 1);
      cnt = {3'b000, p[k]} + {3'b000, n[k]};
      if (k > 0 || TORUS != 0)
        cnt = cnt + {3'b000, p[lc]} + {3'b000, c[lc]} + {3'b000, n[lc]};
      if (k < COLS - 1 || TORUS != 0)
        cnt = cnt + {3'b000, p[rc]} + {3'b000, c[rc]} + {3'b000, n[rc]};
      res[k] = (cnt == 4'd3) || ((cnt == 4'd2) && c[k]);
    end
    return res;
  endfunction

  // Row below the current one: memory data, or the saved row 0 / dead row at the bottom edge.
  always_comb begin
    nxt_in = rd_data;
    if (row_q == LAST_ROW)
      nxt_in = (TORUS != 0) ? row0_q : 32'd0;
  end

  // Next-state, frame pacing and pending-request logic.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    pend_d      = pend_q;
    frame_cnt_d = frame_cnt_q;
    frame_trig  = 1'b0;
    frame_inc   = {1'b0, frame_cnt_q} + 5'd1;
    div_eff     = (frame_div == 4'd0) ? 5'd1 : {1'b0, frame_div};
    case (state_q)
      IDLE: begin
        if (frame_start && step_en) begin
          if (frame_inc >= div_eff) begin
            frame_cnt_d = 4'd0;
            frame_trig  = 1'b1;
          end else begin
            frame_cnt_d = frame_inc[3:0];
          end
        end
        if (step_req || frame_trig)
          state_d = PRIME_A;
      end
      PRIME_A: state_d = PRIME_B;
      PRIME_B: state_d = PRIME_C;
      PRIME_C: begin
        state_d = ROW_RD;
        row_d   = 5'd0;
      end
      ROW_RD:  state_d = ROW_CAP;
      ROW_CAP: state_d = ROW_WR;
      ROW_WR: begin
        if (row_q == LAST_ROW) begin
          state_d = FINISH;
        end else begin
          state_d = ROW_RD;
          row_d   = row_q + 5'd1;
        end
      end
      FINISH: begin
        if (pend_q || step_req) begin
          state_d = PRIME_A;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_q != FINISH && step_req)
      pend_d = 1'b1;
  end

  // Strobes are registered, so they are decided from the state being entered.
  always_comb begin
    rd_go     = 1'b0;
    rd_addr_d = rd_addr;
    wr_go     = 1'b0;
    case (state_d)
      PRIME_A: begin
        rd_go     = 1'b1;
        rd_addr_d = LAST_ROW;
      end
      PRIME_B: begin
        rd_go     = 1'b1;
        rd_addr_d = 5'd0;
      end
      ROW_RD: begin
        if (row_d != LAST_ROW) begin
          rd_go     = 1'b1;
          rd_addr_d = row_d + 5'd1;
        end
      end
      ROW_WR:  wr_go = 1'b1;
      default: rd_go = 1'b0;
    endcase
  end

  // Control state, row index, pacing counter and pending flag.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q     <= IDLE;
      row_q       <= 5'd0;
      pend_q      <= 1'b0;
      frame_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      pend_q      <= pend_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Memory strobes; address and data hold their last value while idle.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      rd_en   <= 1'b0;
      rd_addr <= 5'd0;
      wr_en   <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
    end else begin
      rd_en <= rd_go;
      if (rd_go)
        rd_addr <= rd_addr_d;
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr <= row_q;
        wr_data <= life_row(prev_q, cur_q, nxt_in);
      end
    end
  end

  // Row window: rows are shifted only after their neighbours have been consumed.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      prev_q <= 32'd0;
      cur_q  <= 32'd0;
      nxt_q  <= 32'd0;
      row0_q <= 32'd0;
    end else begin
      case (state_q)
        PRIME_B: prev_q <= (TORUS != 0) ? rd_data : 32'd0;
        PRIME_C: begin
          cur_q  <= rd_data;
          row0_q <= rd_data;
        end
        ROW_CAP: nxt_q <= nxt_in;
        ROW_WR: begin
          prev_q <= cur_q;
          cur_q  <= nxt_q;
        end
        default: nxt_q <= nxt_q;
      endcase
    end
  end

  // Completed-generation counter, wraps naturally at 16 bits.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn)
      gen_count <= 16'd0;
    else if (state_q == FINISH)
      gen_count <= gen_count + 16'd1;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);

endmodule

// File: doc/life_step_ctrl.md
LIFE_STEP_CTRL -- requirements
Module: life_step_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 24, number of grid rows (one 32-bit grid register per row).
REQ-002 SHALL have parameter COLS, default 32, cells per row, one bit per cell, bit c = column c.
REQ-003 SHALL have parameter TORUS, default 1: 1 = edges wrap, 0 = cells outside the grid are dead.
REQ-004 SHALL have ports, one per line:
- out_stream_aclk  in  1  sole clock; all logic on its rising edge.
- periph_resetn  in  1  asynchronous active-low reset.
- step_en  in  1  enables automatic frame-paced generations.
- step_req  in  1  single-cycle pulse requesting one generation.
- frame_start  in  1  single-cycle pulse at the first pixel of each frame.
- frame_div  in  4  frames per generation; 0 is treated as 1.
- rd_en  out  1  grid row read strobe.
- rd_addr  out  5  grid row index to read.
- rd_data  in  32  row data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  grid row write strobe, 1 cycle.
- wr_addr  out  5  grid row index to write.
- wr_data  out  32  next-generation row value.
- busy  out  1  high while a generation is running.
- done  out  1  1-cycle pulse when a generation completes.
- gen_count  out  16  completed generations, wraps 0xFFFF -> 0x0000.

Function
REQ-005 SHALL implement states IDLE, PRIME_A, PRIME_B, PRIME_C, ROW_RD, ROW_CAP, ROW_WR, FINISH.
REQ-006 In IDLE, a frame_start pulse with step_en=1 SHALL increment a frame counter; when the incremented value reaches max(frame_div,1), the counter SHALL clear and a generation SHALL start on the next cycle.
REQ-007 In IDLE, step_req=1 SHALL start a generation on the next cycle, independent of step_en; a simultaneous frame trigger SHALL count as the same single generation.
REQ-008 A step_req during busy SHALL set a one-deep pending flag; FINISH SHALL then go directly to PRIME_A and clear the flag; further requests while pending SHALL be discarded.
REQ-009 frame_start during busy SHALL be ignored and SHALL NOT advance the frame counter; step_en=0 SHALL hold the counter at its current value.
REQ-010 PRIME_A SHALL issue rd_addr=ROWS-1. PRIME_B SHALL capture prev<=rd_data (0 if TORUS=0) and issue rd_addr=0. PRIME_C SHALL capture cur<=rd_data and row0_save<=rd_data, and set row index r=0.
REQ-011 ROW_RD SHALL issue rd_addr=r+1 when r<ROWS-1; no read is issued when r=ROWS-1.
REQ-012 ROW_CAP SHALL capture nxt<=rd_data when r<ROWS-1; otherwise nxt<=row0_save when TORUS=1, or 0 when TORUS=0.
REQ-013 ROW_WR SHALL assert wr_en with wr_addr=r and wr_data=life(prev,cur,nxt), then set prev<=cur, cur<=nxt, r<=r+1.
REQ-014 After r=ROWS-1 is written, the FSM SHALL go to FINISH; otherwise it SHALL return to ROW_RD.
REQ-015 life() per bit c: n = live count of the 8 neighbours from prev/cur/nxt at columns c-1, c, c+1; columns wrap mod COLS if TORUS=1, else out-of-range columns are 0. Result is 1 iff n==3, or n==2 and cur[c]==1; n SHALL be wide enough to hold 8.
REQ-016 Every row write SHALL use original (pre-generation) neighbour values; row 0's original value SHALL come only from row0_save.
REQ-017 busy SHALL be high in all states except IDLE; one generation SHALL take exactly 3+3*ROWS+1 cycles (76 at default), PRIME_A through FINISH.
REQ-018 FINISH SHALL pulse done for 1 cycle and increment gen_count.
REQ-019 rd_en and wr_en SHALL never be high in the same cycle; when rd_en or wr_en is low, rd_addr, wr_addr and wr_data SHALL be held at their last value.

Reset
REQ-020 periph_resetn low SHALL asynchronously force IDLE and clear the frame counter, pending flag, gen_count, rd_en, wr_en, busy and done; addresses, wr_data and window registers SHALL be 0.
REQ-021 Reset asserted mid-generation SHALL abort it with no further writes; rows already written SHALL remain modified.
REQ-022 After reset release, no generation SHALL start until a new trigger arrives.

Verification
REQ-023 Blinker: rows 10,11,12 = 0x00000020, others 0, step_req -> writes row 11 = 0x00000070, rows 10 and 12 = 0, other rows 0; done pulses 76 cycles after start; gen_count=1.
REQ-024 Wrap (TORUS=1): row 0 = 0x80000003, others 0 -> rows 23, 0, 1 = 0x00000001, all others 0.
REQ-025 Edge (TORUS=0): row 0 = 0x00000007 -> row 0 = 0x00000002, row 1 = 0x00000002, row 23 = 0.
REQ-026 Pacing: step_en=1, frame_div=3, 9 frame_start pulses spaced 200 cycles apart -> exactly 3 generations, started after the 3rd, 6th and 9th pulses; with frame_div=0, every pulse triggers a generation.
REQ-027 Pending: 3 step_req pulses during one busy period -> exactly 2 generations total, back-to-back with no IDLE cycle between them; gen_count=2.
REQ-028 Reset at cycle 40 of a run -> busy=0, done never pulses, gen_count=0; the next step_req runs a full 76-cycle generation.
